// File: rtl/bcd_arb_pkg.sv
// Shared constants, FSM encoding and the per-step digit adjust used by the
// round-robin BCD converter.
package bcd_arb_pkg;

    localparam int BIN_W = 16;
    localparam int BCD_W = 20;
    localparam int STEPS = 16;
    localparam logic [3:0] NEG_CODE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (b[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seq.sv
// Iterative double-dabble: start loads the operand, then one adjust+shift per
// cycle for STEPS cycles. done is high during the cycle of the final step.
module bcd_seq
    import bcd_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(STEPS);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [BCD_W-1:0] adj;
    logic             unused_adj_msb;

    assign adj            = dabble_adjust(bcd_q);
    assign unused_adj_msb = adj[BCD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            {bcd_q, bin_q} <= {adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_q          <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(STEPS - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

    // Lets the controller leave CONV on the same edge that completes the result.
    assign done = run_q && (cnt_q == CNT_W'(STEPS - 1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of one shared signed-binary to BCD converter,
// with display-style formatting of each result.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter logic [7:0]  DOT_MASK = 8'h00,
    localparam int         ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [BIN_W*NREQ-1:0] data_in,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic                  out_valid,
    output logic [ID_W-1:0]       out_id,
    output logic [BCD_W-1:0]      data_out,
    output logic [7:0]            dat_en,
    output logic [7:0]            dot_en
);

    state_t           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  grant_q;
    logic             neg_q;
    logic [NREQ-1:0]  ack_q;
    logic             out_valid_q;
    logic [ID_W-1:0]  out_id_q;
    logic [BCD_W-1:0] data_out_q;
    logic [7:0]       dat_en_q;
    logic [7:0]       dot_en_q;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [BIN_W-1:0] op_sel;
    logic [12:0]      mag13;
    logic             start;
    logic             seq_done;
    logic [BCD_W-1:0] seq_bcd;
    logic [BCD_W-1:0] fmt_data;
    logic [7:0]       fmt_en;
    logic             unused_sel;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req[(int'(ptr_q) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign op_sel     = data_in[int'(pick_idx)*BIN_W +: BIN_W];
    assign unused_sel = ^{op_sel[15:13], pick_found};
    assign mag13      = op_sel[12] ? (~{1'b1, op_sel[11:0]}) + 13'd1 : {1'b0, op_sel[11:0]};
    assign start      = (state_q == ST_IDLE) && (|req);

    bcd_seq u_seq (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   ({3'b000, mag13}),
        .done  (seq_done),
        .bcd   (seq_bcd)
    );

    assign fmt_data = neg_q ? {NEG_CODE, seq_bcd[15:0]} : seq_bcd;
    assign fmt_en   = {3'b000, |fmt_data[19:16], 4'b1111};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            neg_q       <= 1'b0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            data_out_q  <= '0;
            dat_en_q    <= '0;
            dot_en_q    <= '0;
        end else begin
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= pick_idx;
                        neg_q   <= op_sel[12];
                        ptr_q   <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (seq_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= 1'b1;
                    ack_q       <= {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
                    out_id_q    <= grant_q;
                    data_out_q  <= fmt_data;
                    dat_en_q    <= fmt_en;
                    dot_en_q    <= DOT_MASK;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign data_out  = data_out_q;
    assign dat_en    = dat_en_q;
    assign dot_en    = dot_en_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed and randomized bench for bcd_conv_arbiter against an arithmetic
// reference (decimal digits by division, round-robin by mask search).
module tb_bcd_conv_arbiter;

    localparam int         NREQ = 4;
    localparam logic [7:0] DOT  = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [16*NREQ-1:0] data_in;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              out_valid;
    logic [1:0]        out_id;
    logic [19:0]       data_out;
    logic [7:0]        dat_en;
    logic [7:0]        dot_en;

    bcd_conv_arbiter #(.NREQ(NREQ), .DOT_MASK(DOT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .busy      (busy),
        .out_valid (out_valid),
        .out_id    (out_id),
        .data_out  (data_out),
        .dat_en    (dat_en),
        .dot_en    (dot_en)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_err    = 0;
    int          ptr_m    = 0;
    int          exp_id   = 0;
    bit          drop_on_ack = 1'b1;
    logic [15:0] ops [NREQ];
    logic [19:0] exp_q [$];
    logic [19:0] last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [19:0] ref_bcd(input logic [15:0] op);
        int   mag;
        logic [19:0] r;
        if (op[12]) mag = 8192 - int'(op[12:0]);
        else        mag = int'(op[11:0]);
        r[3:0]   = 4'(mag % 10);
        r[7:4]   = 4'((mag / 10) % 10);
        r[11:8]  = 4'((mag / 100) % 10);
        r[15:12] = 4'((mag / 1000) % 10);
        r[19:16] = op[12] ? 4'hA : 4'((mag / 10000) % 10);
        return r;
    endfunction

    function automatic logic [7:0] ref_en(input logic [19:0] d);
        return {3'b000, |d[19:16], 4'b1111};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) data_in[16*i +: 16] = ops[i];
    endtask

    // Called just after an edge with the DUT idle: the next edge grants.
    task automatic begin_txn();
        exp_id = rr_pick(req, ptr_m);
        if (exp_id < 0) begin
            check("no_request_to_grant", 32'(req), 32'd1);
            exp_id = 0;
        end
        ptr_m = (exp_id + 1) % NREQ;
        exp_q.push_back(ref_bcd(ops[exp_id]));
    endtask

    task automatic finish_txn(input int pre);
        int          cycles;
        bit          got;
        bit          bad_ack;
        logic [19:0] exp_d;
        cycles  = 0;
        got     = 1'b0;
        bad_ack = 1'b0;
        while (!got && cycles < 40) begin
            tick();
            cycles++;
            if (out_valid) got = 1'b1;
            else if (ack != '0) bad_ack = 1'b1;
        end
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hXXXXX;
        check("latency", 32'(cycles + pre), 32'd18);
        check("ack_outside_valid", 32'(bad_ack), 32'd0);
        check("out_id", 32'(out_id), 32'(exp_id));
        check("ack_onehot", 32'(ack), 32'(1 << exp_id));
        check("data_out", 32'(data_out), 32'(exp_d));
        check("dat_en", 32'(dat_en), 32'(ref_en(exp_d)));
        check("dot_en", 32'(dot_en), 32'(DOT));
        check("busy_at_result", 32'(busy), 32'd0);
        last_data = exp_d;
        if (drop_on_ack) req[exp_id] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_id"}, 32'(out_id), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_daten"}, 32'(dat_en), 32'd0);
        check({tag, "_doten"}, 32'(dot_en), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        ptr_m = 0;
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit saw_ack;
        rst = 1'b1;
        req = '0;
        data_in = '0;
        for (int i = 0; i < NREQ; i++) ops[i] = 16'h0000;
        tick();
        check_all_zero("in_reset");
        do_reset();
        check_all_zero("after_reset");

        // Single positive request at the top of the positive range.
        ops[0] = 16'h0FFF;
        load_ops();
        req = 4'b0001;
        begin_txn();
        finish_txn(0);

        // Negative operands, including ignored upper bits.
        ops[1] = 16'h1F9C;
        ops[2] = 16'h1000;
        ops[3] = 16'hFF9C;
        load_ops();
        for (int i = 1; i < NREQ; i++) begin
            req[i] = 1'b1;
            begin_txn();
            finish_txn(0);
        end

        // Fairness with every request held.
        do_reset();
        for (int i = 0; i < NREQ; i++) ops[i] = 16'($urandom);
        load_ops();
        drop_on_ack = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            begin_txn();
            finish_txn(0);
        end
        req = '0;
        drop_on_ack = 1'b1;
        tick();

        // Late request on 2 while busy, plus a short-lived request on 1.
        ops[0] = 16'h0042;
        ops[2] = 16'h1FFF;
        load_ops();
        req = 4'b0001;
        begin_txn();
        repeat (5) tick();
        check("busy_in_conv", 32'(busy), 32'd1);
        req[2] = 1'b1;
        req[1] = 1'b1;
        repeat (3) tick();
        req[1] = 1'b0;
        finish_txn(8);
        begin_txn();
        finish_txn(0);

        // Reset in the middle of a conversion.
        ops[0] = 16'h0123;
        load_ops();
        req = 4'b0001;
        tick();
        repeat (8) tick();
        rst = 1'b1;
        req = '0;
        #1;
        check_all_zero("mid_reset");
        saw_ack = 1'b0;
        repeat (3) begin
            tick();
            if (ack != '0) saw_ack = 1'b1;
        end
        rst = 1'b0;
        ptr_m = 0;
        repeat (20) begin
            tick();
            if (ack != '0 || out_valid) saw_ack = 1'b1;
        end
        check("no_ack_after_abort", 32'(saw_ack), 32'd0);
        ops[1] = 16'h0456;
        load_ops();
        req = 4'b0010;
        begin_txn();
        finish_txn(0);

        // Requester 3 drops its request right after grant, zero operand.
        ops[3] = 16'h0000;
        load_ops();
        req = 4'b1000;
        begin_txn();
        tick();
        req[3] = 1'b0;
        finish_txn(1);

        // Random request masks and operands.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) ops[i] = 16'($urandom);
            load_ops();
            req = 4'($urandom_range(1, 15));
            while (req != '0) begin
                begin_txn();
                finish_txn(0);
            end
        end

        // Results hold until the next conversion completes.
        repeat (3) tick();
        check("hold_data", 32'(data_out), 32'(last_data));
        check("hold_daten", 32'(dat_en), 32'(ref_en(last_data)));
        check("hold_valid", 32'(out_valid), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
